// File: rtl/ysyx_24100027_lsu.sv
// Load/store unit: lane mask/shift for stores, align + sign/zero-extend for loads.
// Latency: accept -> out_valid in 3 cycles minimum; one op in flight, 1 op per 4 cycles best case.
// Backpressure: in_ready only in IDLE; mem_req_valid/fields held until mem_req_ready; result held until out_ready.
//
// Ports: execute side  in_valid/in_ready, in_addr, in_wdata, in_memop, in_wen
//        memory side   mem_req_valid/mem_req_ready, mem_we, mem_addr, mem_wdata, mem_wmask,
//                      mem_rsp_valid, mem_rdata
//        write-back    out_valid/out_ready, out_rdata, out_err
// Optional feature macro: YSYX_24100027_LSU_MISALIGN_EN
//   defined   : misaligned h/hu/w accesses skip memory and return out_err=1, out_rdata=0
//   undefined : out_err tied 0; halves forced to offset addr[1]*2, words to offset 0
module ysyx_24100027_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_memop,
    input  logic        in_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic        is_b_q;
    logic        is_h_q;
    logic        uns_q;

    // decode of the incoming operation
    logic        in_is_b;
    logic        in_is_h;
    logic [1:0]  in_off;
    logic [3:0]  in_mask;
    logic        in_mis;

    // load alignment from the latched access
    logic [31:0] rd_shift;
    logic [31:0] ld_data;

    assign in_ready = (state == IDLE);

    always_comb begin
        // 011/110/111 fall through to word
        in_is_b = (in_memop[1:0] == 2'b00);
        in_is_h = (in_memop[1:0] == 2'b01);
`ifdef YSYX_24100027_LSU_MISALIGN_EN
        in_off  = in_addr[1:0];
        in_mis  = (in_is_h && in_addr[0]) || (!in_is_b && !in_is_h && (in_addr[1:0] != 2'b00));
`else
        // forced offsets keep every lane inside the word
        in_off  = in_is_b ? in_addr[1:0] : (in_is_h ? {in_addr[1], 1'b0} : 2'b00);
        in_mis  = 1'b0;
`endif
        if (in_is_b)
            in_mask = 4'b0001 << in_off;
        else if (in_is_h)
            in_mask = 4'b0011 << in_off;
        else
            in_mask = 4'b1111;
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        if (is_b_q)
            ld_data = {{24{rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
        else if (is_h_q)
            ld_data = {{16{rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
        else
            ld_data = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            mem_wmask     <= 4'h0;
            out_valid     <= 1'b0;
            out_rdata     <= 32'h0;
            off_q         <= 2'b00;
            is_b_q        <= 1'b0;
            is_h_q        <= 1'b0;
            uns_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mem_addr  <= {in_addr[31:2], 2'b00};
                        mem_we    <= in_wen;
                        mem_wdata <= in_wdata << {in_off, 3'b000};
                        mem_wmask <= in_wen ? in_mask : 4'h0;
                        off_q     <= in_off;
                        is_b_q    <= in_is_b;
                        is_h_q    <= in_is_h;
                        uns_q     <= in_memop[2];
                        if (in_mis) begin
                            // error path never touches memory
                            out_valid <= 1'b1;
                            out_rdata <= 32'h0;
                            state     <= RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        out_rdata <= mem_we ? 32'h0 : ld_data;
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef YSYX_24100027_LSU_MISALIGN_EN
    // error flag is captured with the accept decision and held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_err <= 1'b0;
        else if (state == IDLE && in_valid)
            out_err <= in_mis;
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100027_lsu.sv
module tb_ysyx_24100027_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_wen;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_memop;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    ysyx_24100027_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_memop(in_memop), .in_wen(in_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [2:0]  memop;
        logic        wen;
        int          rdy, rsp, odly;
        bit          lat;
    } op_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  mask;
        logic        we;
        int          rdy, rsp;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          odly, t0;
        bit          lat;
    } exp_t;

    req_t req_q[$];
    exp_t out_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference model: byte-level view of the access, computed from sizes and offsets.
    function automatic void model(input op_t o, output bit issue, output req_t r, output exp_t e);
        int     size, a, off;
        bit     mis;
        longint v;
        size = (o.memop[1:0] == 2'b00) ? 1 : ((o.memop[1:0] == 2'b01) ? 2 : 4);
        a    = int'(o.addr[1:0]);
`ifdef YSYX_24100027_LSU_MISALIGN_EN
        mis = (a % size) != 0;
        off = a;
`else
        mis = 1'b0;
        off = (a / size) * size;
`endif
        r.addr  = o.addr & 32'hFFFF_FFFC;
        r.we    = o.wen;
        r.mask  = o.wen ? 4'(((1 << size) - 1) << off) : 4'h0;
        r.wdata = 32'(longint'(o.wdata) << (8 * off));
        r.rdata = o.rdata;
        r.rdy   = o.rdy;
        r.rsp   = o.rsp;
        v = (longint'(o.rdata) >> (8 * off)) % (longint'(1) << (8 * size));
        if (!o.memop[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        issue   = !mis;
        e.rdata = (o.wen || mis) ? 32'h0 : 32'(v);
        e.err   = mis;
        e.odly  = o.odly;
        e.lat   = o.lat;
        e.t0    = 0;
    endfunction

    task automatic issue_op(input op_t o);
        int   w;
        bit   go;
        req_t r;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            return;
        end
        in_valid = 1'b1;
        in_addr  = o.addr;
        in_wdata = o.wdata;
        in_memop = o.memop;
        in_wen   = o.wen;
        model(o, go, r, e);
        e.t0 = cyc;
        if (go) req_q.push_back(r);
        out_q.push_back(e);
        @(negedge clk);
        // scramble inputs so the DUT must rely on its latched copy
        in_valid = 1'b0;
        in_addr  = $urandom;
        in_wdata = $urandom;
        in_memop = 3'($urandom);
        in_wen   = 1'($urandom);
    endtask

    // memory responder: checks request fields every cycle they are presented
    task automatic mem_proc();
        int   rdy_cnt  = 0;
        int   rsp_wait = -1;
        req_t cur;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            mem_rdata     = $urandom;
            if (rsp_wait >= 0) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = cur.rdata;
                end
                rsp_wait--;
            end else if (mem_req_valid) begin
                chk("in_ready_during_req", 32'(in_ready), 32'h0);
                if (req_q.size() == 0) begin
                    fail_now("unexpected_mem_req");
                end else begin
                    cur = req_q[0];
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    chk("mem_wmask", 32'(mem_wmask), 32'(cur.mask));
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                    if (rdy_cnt >= cur.rdy) begin
                        mem_req_ready = 1'b1;
                        void'(req_q.pop_front());
                        rdy_cnt  = 0;
                        rsp_wait = cur.rsp;
                    end else begin
                        rdy_cnt++;
                        if ($urandom_range(3) == 0) mem_rsp_valid = 1'b1;  // stray, must be ignored
                    end
                end
            end else if (out_valid && $urandom_range(2) == 0) begin
                mem_rsp_valid = 1'b1;  // stray during RESP
            end
        end
    endtask

    // write-back monitor: pops expected results whenever out_valid is presented
    task automatic mon_proc();
        int   ocnt     = 0;
        bit   chk_idle = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            out_ready = 1'b0;
            if (chk_idle) begin
                chk("in_ready_after_out", 32'(in_ready), 32'h1);
                chk_idle = 1'b0;
            end
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = out_q[0];
                    if (ocnt == 0 && e.lat) chk("min_latency", 32'(cyc - e.t0), 32'd3);
                    chk("out_rdata", out_rdata, e.rdata);
                    chk("out_err", 32'(out_err), 32'(e.err));
                    chk("in_ready_during_resp", 32'(in_ready), 32'h0);
                    if (ocnt >= e.odly) begin
                        out_ready = 1'b1;
                        void'(out_q.pop_front());
                        ocnt     = 0;
                        chk_idle = e.lat;
                    end else begin
                        ocnt++;
                    end
                end
            end
        end
    endtask

    op_t dir_ops[$];

    initial begin
        op_t o;
        int  w;
        rst_n = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_memop = '0; in_wen = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_rdata", out_rdata, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        rst_n = 1'b1;

        // reset while waiting for a response; the late response must be ignored
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h8000_0004; in_memop = 3'b010; in_wen = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rw_req_valid", 32'(mem_req_valid), 32'h1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rw_wait_req_low", 32'(mem_req_valid), 32'h0);
        chk("rw_wait_out_low", 32'(out_valid), 32'h0);
        #2 rst_n = 1'b0;
        #1 chk("rw_async_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rw_post_out_valid", 32'(out_valid), 32'h0);
        chk("rw_post_in_ready", 32'(in_ready), 32'h1);
        chk("rw_post_req_valid", 32'(mem_req_valid), 32'h0);
        @(negedge clk);
        chk("rw_post2_out_valid", 32'(out_valid), 32'h0);

        fork
            mem_proc();
            mon_proc();
        join_none

        //           addr          wdata         rdata         memop   wen  rdy rsp odly lat
        dir_ops.push_back('{32'h8000_0003, 32'h0000_00AB, 32'h1111_1111, 3'b000, 1'b1, 0, 0, 0, 1'b1});
        dir_ops.push_back('{32'h8000_0002, 32'h0,         32'h8123_4567, 3'b001, 1'b0, 0, 0, 0, 1'b1});
        dir_ops.push_back('{32'h8000_0002, 32'h0,         32'h8123_4567, 3'b101, 1'b0, 0, 0, 0, 1'b1});
        dir_ops.push_back('{32'h8000_0010, 32'h0,         32'hCAFE_F00D, 3'b010, 1'b0, 5, 2, 3, 1'b0});
        dir_ops.push_back('{32'h8000_0001, 32'h1234_5678, 32'h0,         3'b010, 1'b1, 0, 0, 0, 1'b0});
        dir_ops.push_back('{32'h8000_0001, 32'h0,         32'h8765_4321, 3'b010, 1'b0, 1, 1, 1, 1'b0});
        dir_ops.push_back('{32'h8000_0003, 32'h0,         32'h80FF_FFFF, 3'b000, 1'b0, 0, 0, 0, 1'b1});
        dir_ops.push_back('{32'h8000_0003, 32'h0,         32'h80FF_FFFF, 3'b100, 1'b0, 0, 0, 0, 1'b1});
        foreach (dir_ops[i]) issue_op(dir_ops[i]);

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            o.addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            o.wdata = $urandom;
            o.rdata = $urandom;
            o.memop = 3'($urandom);
            o.wen   = 1'($urandom);
            o.rdy   = $urandom_range(3);
            o.rsp   = $urandom_range(2);
            o.odly  = $urandom_range(2);
            o.lat   = 1'b0;
            issue_op(o);
        end

        w = 0;
        while ((out_q.size() != 0 || req_q.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (out_q.size() != 0 || req_q.size() != 0) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
